// File: rtl/cpu_bus_ctrl_if.sv
// rtl/cpu_bus_ctrl_if.sv - CPU access bus plus external device port bundle
interface cpu_bus_ctrl_if;
  logic        acc_en;
  logic [15:0] addr;
  logic        r_w_n;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_vld;
  logic        rdy;
  logic        dev_req;
  logic        dev_we;
  logic [15:0] dev_addr;
  logic [7:0]  dev_wdata;
  logic [7:0]  dev_rdata;
  logic        dev_ack;
  logic        bus_err;

  modport master (
    output acc_en, addr, r_w_n, wdata, dev_rdata, dev_ack,
    input  rdata, rdata_vld, rdy, dev_req, dev_we, dev_addr, dev_wdata, bus_err
  );

  modport slave (
    input  acc_en, addr, r_w_n, wdata, dev_rdata, dev_ack,
    output rdata, rdata_vld, rdy, dev_req, dev_we, dev_addr, dev_wdata, bus_err
  );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - mirrored work RAM plus stalled req/ack device port behind the CPU pins
module cpu_bus_ctrl #(
  parameter int          RAM_AW     = 11,
  parameter logic [15:0] MIRROR_END = 16'h2000,
  parameter int          TIMEOUT    = 16,
  parameter logic [7:0]  OPEN_BUS   = 8'hFF
) (
  input logic           clk,
  input logic           reset_n,
  cpu_bus_ctrl_if.slave bus
);

  localparam int             TW    = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DEV_WAIT, DEV_DONE} state_e;

  state_e        state_q;
  logic          rdy_q;
  logic [7:0]    rdata_q;
  logic          rdata_vld_q;
  logic          dev_req_q;
  logic          dev_we_q;
  logic [15:0]   dev_addr_q;
  logic [7:0]    dev_wdata_q;
  logic          bus_err_q;
  logic [TW-1:0] timer_q;

  logic [7:0]        mem [2**RAM_AW];
  logic              ram_hit;
  logic              accept;
  logic              ram_wr;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit = (bus.addr < MIRROR_END);
  assign ram_idx = bus.addr[RAM_AW-1:0];
  assign accept  = (state_q == IDLE) && rdy_q && bus.acc_en;
  assign ram_wr  = reset_n && accept && ram_hit && !bus.r_w_n;

  // RAM contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_idx] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      rdata_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (ram_hit) begin
              if (bus.r_w_n) begin
                rdata_q     <= mem[ram_idx];
                rdata_vld_q <= 1'b1;
              end
            end else begin
              dev_req_q   <= 1'b1;
              dev_we_q    <= ~bus.r_w_n;
              dev_addr_q  <= bus.addr;
              dev_wdata_q <= bus.wdata;
              rdy_q       <= 1'b0;
              timer_q     <= '0;
              state_q     <= DEV_WAIT;
            end
          end
        end
        DEV_WAIT: begin
          timer_q <= timer_q + 1'b1;
          // An ack in the final timer cycle still completes normally.
          if (bus.dev_ack) begin
            dev_req_q   <= 1'b0;
            rdy_q       <= 1'b1;
            rdata_vld_q <= ~dev_we_q;
            if (!dev_we_q) begin
              rdata_q <= bus.dev_rdata;
            end
            state_q <= DEV_DONE;
          end else if (timer_q == TLAST) begin
            dev_req_q   <= 1'b0;
            bus_err_q   <= 1'b1;
            rdy_q       <= 1'b1;
            rdata_vld_q <= ~dev_we_q;
            if (!dev_we_q) begin
              rdata_q <= OPEN_BUS;
            end
            state_q <= DEV_DONE;
          end
        end
        DEV_DONE: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = rdata_vld_q;
  assign bus.dev_req   = dev_req_q;
  assign bus.dev_we    = dev_we_q;
  assign bus.dev_addr  = dev_addr_q;
  assign bus.dev_wdata = dev_wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - directed plus randomized bench for cpu_bus_ctrl against a RAM/transaction model
module tb_cpu_bus_ctrl;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cpu_bus_ctrl_if bus();

  cpu_bus_ctrl #(
    .RAM_AW(11), .MIRROR_END(16'h2000), .TIMEOUT(TIMEOUT), .OPEN_BUS(8'hFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] ram_m [2048];
  bit         ram_v [2048];
  logic       err_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ram_op(input bit wr, input logic [15:0] a, input logic [7:0] d);
    logic [10:0] i;
    logic [7:0]  exp;
    bit          known;
    i     = a[10:0];
    exp   = ram_m[i];
    known = ram_v[i];
    bus.acc_en = 1'b1;
    bus.addr   = a;
    bus.r_w_n  = ~wr;
    bus.wdata  = d;
    if (wr) begin
      ram_m[i] = d;
      ram_v[i] = 1'b1;
    end
    step();
    chk("ram_rdy", 32'(bus.rdy), 32'd1);
    chk("ram_vld", 32'(bus.rdata_vld), 32'(!wr));
    if (!wr && known) chk("ram_rdata", 32'(bus.rdata), 32'(exp));
  endtask

  // ack_at: DEV_WAIT cycle index (0 = first cycle dev_req is high) at which dev_ack pulses; <0 = never
  task automatic dev_op(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input int ack_at, input logic [7:0] drd);
    int   low;
    bit   acked;
    int   exp_low;
    low   = 0;
    acked = (ack_at >= 0) && (ack_at < TIMEOUT);
    exp_low = acked ? ack_at + 1 : TIMEOUT;
    bus.acc_en = 1'b1;
    bus.addr   = a;
    bus.r_w_n  = ~wr;
    bus.wdata  = d;
    step();
    bus.acc_en = 1'b0;
    chk("dev_req_up", 32'(bus.dev_req), 32'd1);
    chk("dev_addr", 32'(bus.dev_addr), 32'(a));
    chk("dev_we", 32'(bus.dev_we), 32'(wr));
    if (wr) chk("dev_wdata", 32'(bus.dev_wdata), 32'(d));
    for (int j = 0; j < TIMEOUT + 4; j++) begin
      if (bus.rdy == 1'b0) low++;
      if (j == ack_at) begin
        bus.dev_ack   = 1'b1;
        bus.dev_rdata = drd;
      end
      step();
      bus.dev_ack   = 1'b0;
      bus.dev_rdata = 8'($urandom);
      if (bus.dev_req == 1'b0) break;
    end
    chk("dev_stall_len", 32'(low), 32'(exp_low));
    if (!acked) err_m = 1'b1;
    chk("done_rdy", 32'(bus.rdy), 32'd1);
    chk("done_req", 32'(bus.dev_req), 32'd0);
    chk("done_vld", 32'(bus.rdata_vld), 32'(!wr));
    if (!wr) chk("done_rdata", 32'(bus.rdata), acked ? 32'(drd) : 32'hFF);
    chk("done_bus_err", 32'(bus.bus_err), 32'(err_m));
    // An access offered in DEV_DONE must be dropped; 0x0010 is re-read later.
    bus.acc_en = 1'b1;
    bus.addr   = 16'h0010;
    bus.r_w_n  = 1'b0;
    bus.wdata  = 8'($urandom);
    step();
    bus.acc_en = 1'b0;
    chk("post_vld", 32'(bus.rdata_vld), 32'd0);
    chk("post_req", 32'(bus.dev_req), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 2048; i++) ram_v[i] = 1'b0;
    err_m         = 1'b0;
    bus.acc_en    = 1'b0;
    bus.addr      = '0;
    bus.r_w_n     = 1'b1;
    bus.wdata     = '0;
    bus.dev_ack   = 1'b0;
    bus.dev_rdata = '0;
    reset_n       = 1'b0;
    step();
    step();
    chk("rst_rdy", 32'(bus.rdy), 32'd1);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_vld", 32'(bus.rdata_vld), 32'd0);
    chk("rst_req", 32'(bus.dev_req), 32'd0);
    chk("rst_we", 32'(bus.dev_we), 32'd0);
    chk("rst_daddr", 32'(bus.dev_addr), 32'd0);
    chk("rst_dwdata", 32'(bus.dev_wdata), 32'd0);
    chk("rst_err", 32'(bus.bus_err), 32'd0);
    reset_n = 1'b1;
    step();

    ram_op(1'b1, 16'h0010, 8'hC3);
    ram_op(1'b1, 16'h0042, 8'h5A);
    ram_op(1'b0, 16'h0842, 8'h00);
    bus.acc_en = 1'b0;
    step();
    chk("idle_vld", 32'(bus.rdata_vld), 32'd0);

    dev_op(1'b0, 16'h2002, 8'h00, 3, 8'h80);
    dev_op(1'b0, 16'h2345, 8'h00, TIMEOUT - 1, 8'h6E);
    dev_op(1'b1, 16'hA001, 8'h99, 0, 8'h00);

    for (int k = 0; k < 40; k++) begin
      a = 16'({2'($urandom_range(0, 3)), 11'(11'h40 + $urandom_range(0, 7))});
      d = 8'($urandom);
      ram_op(1'($urandom_range(0, 1)), a, d);
    end
    bus.acc_en = 1'b0;
    step();

    for (int k = 0; k < 5; k++) begin
      a = 16'($urandom_range(16'h2000, 16'hFFFF));
      dev_op(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, TIMEOUT - 1), 8'($urandom));
    end

    dev_op(1'b1, 16'h4016, 8'h01, -1, 8'h00);
    dev_op(1'b0, 16'h8000, 8'h00, -1, 8'h00);
    dev_op(1'b0, 16'h8001, 8'h00, TIMEOUT - 1, 8'h3C);

    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom_range(16'h2000, 16'hFFFF));
      dev_op(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, TIMEOUT + 3), 8'($urandom));
    end

    bus.acc_en = 1'b1;
    bus.addr   = 16'h3000;
    bus.r_w_n  = 1'b1;
    step();
    bus.acc_en = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
    chk("midrst_req", 32'(bus.dev_req), 32'd0);
    chk("midrst_rdy", 32'(bus.rdy), 32'd1);
    chk("midrst_err", 32'(bus.bus_err), 32'd0);
    reset_n = 1'b1;
    err_m   = 1'b0;
    bus.dev_ack   = 1'b1;
    bus.dev_rdata = 8'h33;
    step();
    bus.dev_ack = 1'b0;
    chk("stray_req", 32'(bus.dev_req), 32'd0);
    chk("stray_rdy", 32'(bus.rdy), 32'd1);
    chk("stray_vld", 32'(bus.rdata_vld), 32'd0);
    chk("stray_rdata", 32'(bus.rdata), 32'd0);
    ram_op(1'b0, 16'h1842, 8'h00);
    ram_op(1'b0, 16'h0010, 8'h00);
    bus.acc_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
